// File: rtl/unidad_mult_div_pkg.sv
// ---------------------------------------------------------------------------
// unidad_md_pkg
// Shared types and constants for the iterative multiply/divide unit.
//   op_e      : operation code carried from the control unit
//   state_e   : sequencing FSM states
//   DEF_WIDTH : default operand/result width
//   ITER      : number of one-bit iterations per operation
// Optional feature macro used by this unit: UNIDAD_MD_EARLY_TERM_EN
// ---------------------------------------------------------------------------
package unidad_md_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int ITER      = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  function automatic logic op_is_div(op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/unidad_mult_div_if.sv
// ---------------------------------------------------------------------------
// unidad_mult_div_if
// Control/operand/result bundle between the control unit (master) and the
// multiply/divide unit (slave).
//   start, op, rs_data, rt_data : request side (master -> slave)
//   busy, done, div_by_zero     : status (slave -> master)
//   hi, lo                      : result registers (slave -> master)
// Optional feature macro used by this unit: UNIDAD_MD_EARLY_TERM_EN (no effect here)
// ---------------------------------------------------------------------------
interface unidad_mult_div_if
  import unidad_md_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             start;
  op_e              op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data,
    output busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/unidad_mult_div_sign_fix.sv
// ---------------------------------------------------------------------------
// md_sign_fix
// Combinational sign handling for the multiply/divide unit.
//   signed_i, a_i, b_i       : raw operands; sign_*_o / mag_*_o give the sign
//                              bits and magnitudes latched at acceptance
//   is_mult_i, neg_a_i,
//   neg_b_i, res_i           : unsigned {hi,lo} result and latched signs
//   res_o                    : sign-corrected {hi,lo}
// Optional feature macro used by this unit: UNIDAD_MD_EARLY_TERM_EN (no effect here)
// ---------------------------------------------------------------------------
module md_sign_fix
  import unidad_md_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               sign_a_o,
  output logic               sign_b_o,
  output logic [WIDTH-1:0]   mag_a_o,
  output logic [WIDTH-1:0]   mag_b_o,
  input  logic               is_mult_i,
  input  logic               neg_a_i,
  input  logic               neg_b_i,
  input  logic [2*WIDTH-1:0] res_i,
  output logic [2*WIDTH-1:0] res_o
);

  logic [2*WIDTH-1:0] res_neg;
  logic [WIDTH-1:0]   hi_neg;
  logic [WIDTH-1:0]   lo_neg;

  assign sign_a_o = signed_i & a_i[WIDTH-1];
  assign sign_b_o = signed_i & b_i[WIDTH-1];
  // The most negative value maps to itself, which is its correct unsigned magnitude.
  assign mag_a_o  = sign_a_o ? -a_i : a_i;
  assign mag_b_o  = sign_b_o ? -b_i : b_i;

  assign res_neg = -res_i;
  assign hi_neg  = -res_i[2*WIDTH-1:WIDTH];
  assign lo_neg  = -res_i[WIDTH-1:0];

  always_comb begin
    if (is_mult_i) begin
      res_o = (neg_a_i ^ neg_b_i) ? res_neg : res_i;
    end else begin
      // Quotient sign follows the operand signs; remainder follows the dividend.
      res_o = {(neg_a_i ? hi_neg : res_i[2*WIDTH-1:WIDTH]),
               ((neg_a_i ^ neg_b_i) ? lo_neg : res_i[WIDTH-1:0])};
    end
  end

endmodule

// File: rtl/unidad_mult_div.sv
// ---------------------------------------------------------------------------
// unidad_mult_div
// Iterative shift-add multiplier / restoring divider, one bit per clock,
// feeding the HI/LO registers.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   md    : slave side of unidad_mult_div_if (start/op/rs_data/rt_data in,
//           busy/done/div_by_zero/hi/lo out)
// Optional feature: define UNIDAD_MD_EARLY_TERM_EN to let multiplies leave
// CALC as soon as the remaining multiplier bits are zero.
// ---------------------------------------------------------------------------
module unidad_mult_div
  import unidad_md_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  unidad_mult_div_if.slave  md
);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0]   b_q, b_d;          // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;      // product, or {remainder, quotient}
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               dbz_q, dbz_d;
  logic               busy, done;

  logic               in_sa, in_sb, div_zero;
  logic [WIDTH-1:0]   in_ma, in_mb;
  logic [2*WIDTH-1:0] fixed_res;

  md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .signed_i  (op_is_signed(md.op)),
    .a_i       (md.rs_data),
    .b_i       (md.rt_data),
    .sign_a_o  (in_sa),
    .sign_b_o  (in_sb),
    .mag_a_o   (in_ma),
    .mag_b_o   (in_mb),
    .is_mult_i (!op_is_div(op_q)),
    .neg_a_i   (sa_q),
    .neg_b_i   (sb_q),
    .res_i     (acc_q),
    .res_o     (fixed_res)
  );

  assign div_zero = (md.rt_data == '0);

  // One iteration of each algorithm.
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_step, div_step;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;

  assign add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
  assign mul_step = mplier_q[0] ? {add_sum, acc_q[WIDTH-1:1]}
                                : {1'b0, acc_q[2*WIDTH-1:1]};
  // The shifted remainder needs WIDTH+1 bits for the compare, but the
  // difference always fits in WIDTH bits because it is below the divisor.
  assign div_ge   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} >= {1'b0, b_q};
  assign div_rem  = {acc_q[2*WIDTH-2:WIDTH], acc_q[WIDTH-1]} - b_q;
  assign div_step = div_ge ? {div_rem, acc_q[WIDTH-2:0], 1'b1}
                           : {acc_q[2*WIDTH-2:0], 1'b0};

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

`ifdef UNIDAD_MD_EARLY_TERM_EN
  localparam logic [CNT_W:0] ITER_C = (CNT_W+1)'(ITER);
  logic [CNT_W:0] shamt;
  // Skipped iterations would only shift right, so do them all at once.
  assign shamt = ITER_C - {1'b0, cnt_q};
`endif

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MULT;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      b_q      <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      b_q      <= b_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (md.start) begin
          state_d = (op_is_div(md.op) && div_zero) ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (cnt_q == LAST_CNT) state_d = ST_FIX;
`ifdef UNIDAD_MD_EARLY_TERM_EN
        if (!op_is_div(op_q) && (mplier_q == '0)) state_d = ST_FIX;
`endif
      end
      ST_FIX:  state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    b_d      = b_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (md.start) begin
          op_d  = md.op;
          sa_d  = in_sa;
          sb_d  = in_sb;
          cnt_d = '0;
          dbz_d = 1'b0;
          if (op_is_div(md.op)) begin
            b_d      = in_mb;
            mplier_d = '0;
            acc_d    = {{WIDTH{1'b0}}, in_ma};
            if (div_zero) begin
              hi_d  = md.rs_data;
              lo_d  = '1;
              dbz_d = 1'b1;
            end
          end else begin
            b_d      = in_ma;
            mplier_d = in_mb;
            acc_d    = '0;
          end
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_is_div(op_q)) begin
          acc_d = div_step;
        end else begin
          acc_d    = mul_step;
          mplier_d = mplier_q >> 1;
`ifdef UNIDAD_MD_EARLY_TERM_EN
          if (mplier_q == '0) acc_d = acc_q >> shamt;
`endif
        end
      end
      ST_FIX: begin
        hi_d = fixed_res[2*WIDTH-1:WIDTH];
        lo_d = fixed_res[WIDTH-1:0];
      end
      default: ;
    endcase
  end

  // Output decode.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_CALC, ST_FIX: busy = 1'b1;
      ST_DONE:         done = 1'b1;
      default: ;
    endcase
  end

  assign md.busy        = busy;
  assign md.done        = done;
  assign md.div_by_zero = dbz_q;
  assign md.hi          = hi_q;
  assign md.lo          = lo_q;

endmodule

// File: tb/tb_unidad_mult_div.sv
// ---------------------------------------------------------------------------
// tb_unidad_mult_div
// Directed self-checking bench for unidad_mult_div. Expected values are
// hand-computed. Latency expectations follow UNIDAD_MD_EARLY_TERM_EN.
// ---------------------------------------------------------------------------
module tb_unidad_mult_div;
  import unidad_md_pkg::*;

`ifdef UNIDAD_MD_EARLY_TERM_EN
  localparam int LAT_FFFF = 18;
  localparam int LAT_X1   = 3;
`else
  localparam int LAT_FFFF = 33;
  localparam int LAT_X1   = 33;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  unidad_mult_div_if #(.WIDTH(32)) bus ();

  unidad_mult_div dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation; return latency (edges after acceptance until done),
  // busy-cycle count, the result seen with done, and done one cycle later.
  task automatic run_op(input op_e op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcnt, output logic [31:0] r_hi,
                        output logic [31:0] r_lo, output logic r_dbz, output logic done_after);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.rs_data = a; bus.rt_data = b;
    @(posedge clk); #1;
    // Operands change right after acceptance; the result must not care.
    bus.start = 1'b0; bus.op = OP_DIV; bus.rs_data = 32'hDEAD_BEEF; bus.rt_data = 32'h0;
    lat = 0; bcnt = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL run_op_timeout: done=%b after %0d cycles, want 1", bus.done, lat); end
    r_hi = bus.hi; r_lo = bus.lo; r_dbz = bus.div_by_zero;
    @(posedge clk); #1;
    done_after = bus.done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = OP_MULT; bus.rs_data = '0; bus.rt_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 00000000", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 00000000", bus.lo); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_multu();
    int lat, bcnt; logic [31:0] h, l; logic z, da;
    run_op(OP_MULTU, 32'h0000FFFF, 32'h0000FFFF, lat, bcnt, h, l, z, da);
    $display("MULTU 0000ffff*0000ffff -> hi=%h lo=%h lat=%0d", h, l, lat);
    checks++; if (h !== 32'h00000000) begin errors++; $display("FAIL multu_hi: got %h want 00000000", h); end
    checks++; if (l !== 32'hFFFE0001) begin errors++; $display("FAIL multu_lo: got %h want fffe0001", l); end
    checks++; if (lat !== LAT_FFFF) begin errors++; $display("FAIL multu_latency: got %0d want %0d", lat, LAT_FFFF); end
    checks++; if (bcnt !== LAT_FFFF) begin errors++; $display("FAIL multu_busy_cycles: got %0d want %0d", bcnt, LAT_FFFF); end
    checks++; if (da !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b want 0", da); end
  endtask

  task automatic test_signed();
    int lat, bcnt; logic [31:0] h, l; logic z, da;
    run_op(OP_MULT, 32'hFFFFFFFD, 32'h00000007, lat, bcnt, h, l, z, da);
    $display("MULT fffffffd*00000007 -> hi=%h lo=%h", h, l);
    checks++; if (h !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_neg_hi: got %h want ffffffff", h); end
    checks++; if (l !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_neg_lo: got %h want ffffffeb", l); end
    run_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002, lat, bcnt, h, l, z, da);
    $display("DIV fffffff9/00000002 -> hi=%h lo=%h lat=%0d", h, l, lat);
    checks++; if (l !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg_quot: got %h want fffffffd", l); end
    checks++; if (h !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_rem: got %h want ffffffff", h); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency: got %0d want 33", lat); end
  endtask

  task automatic test_div_by_zero();
    int lat, bcnt; logic [31:0] h, l; logic z, da;
    run_op(OP_DIVU, 32'h00000064, 32'h0, lat, bcnt, h, l, z, da);
    $display("DIVU 00000064/0 -> hi=%h lo=%h dbz=%b lat=%0d", h, l, z, lat);
    checks++; if (lat !== 0) begin errors++; $display("FAIL dbz_latency: got %0d want 0", lat); end
    checks++; if (z !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b want 1", z); end
    checks++; if (h !== 32'h00000064) begin errors++; $display("FAIL dbz_hi: got %h want 00000064", h); end
    checks++; if (l !== 32'hFFFFFFFF) begin errors++; $display("FAIL dbz_lo: got %h want ffffffff", l); end
    checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_sticky: got %b want 1", bus.div_by_zero); end
    run_op(OP_DIVU, 32'h00000064, 32'h00000007, lat, bcnt, h, l, z, da);
    $display("DIVU 00000064/00000007 -> hi=%h lo=%h dbz=%b", h, l, z);
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL dbz_cleared: got %b want 0", z); end
    checks++; if (l !== 32'h0000000E) begin errors++; $display("FAIL divu_quot: got %h want 0000000e", l); end
    checks++; if (h !== 32'h00000002) begin errors++; $display("FAIL divu_rem: got %h want 00000002", h); end
  endtask

  task automatic test_div_overflow();
    int lat, bcnt; logic [31:0] h, l; logic z, da;
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bcnt, h, l, z, da);
    $display("DIV 80000000/ffffffff -> hi=%h lo=%h dbz=%b", h, l, z);
    checks++; if (l !== 32'h80000000) begin errors++; $display("FAIL div_ovf_quot: got %h want 80000000", l); end
    checks++; if (h !== 32'h00000000) begin errors++; $display("FAIL div_ovf_rem: got %h want 00000000", h); end
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL div_ovf_dbz: got %b want 0", z); end
  endtask

  task automatic test_start_while_busy();
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULTU; bus.rs_data = 32'h0000FFFF; bus.rt_data = 32'h0000FFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (lat == 4) begin
        bus.start = 1'b1; bus.op = OP_DIVU; bus.rs_data = 32'h5; bus.rt_data = 32'h0;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    $display("MULTU with start at k+5 -> hi=%h lo=%h dbz=%b lat=%0d", bus.hi, bus.lo, bus.div_by_zero, lat);
    checks++; if (lat !== LAT_FFFF) begin errors++; $display("FAIL busy_start_latency: got %0d want %0d", lat, LAT_FFFF); end
    checks++; if (bus.lo !== 32'hFFFE0001) begin errors++; $display("FAIL busy_start_lo: got %h want fffe0001", bus.lo); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL busy_start_dbz: got %b want 0", bus.div_by_zero); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat, bcnt; logic [31:0] h, l; logic z, da;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULTU; bus.rs_data = 32'h00001234; bus.rt_data = 32'h00005678;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    $display("reset at k+10 -> busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL midreset_hi: got %h want 00000000", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL midreset_lo: got %h want 00000000", bus.lo); end
    @(negedge clk); rst_n = 1'b1;
    run_op(OP_MULT, 32'h00000010, 32'hFFFFFFFE, lat, bcnt, h, l, z, da);
    $display("MULT 00000010*fffffffe -> hi=%h lo=%h", h, l);
    checks++; if (h !== 32'hFFFFFFFF) begin errors++; $display("FAIL post_reset_hi: got %h want ffffffff", h); end
    checks++; if (l !== 32'hFFFFFFE0) begin errors++; $display("FAIL post_reset_lo: got %h want ffffffe0", l); end
  endtask

  task automatic test_early_term();
    int lat, bcnt; logic [31:0] h, l; logic z, da;
    run_op(OP_MULTU, 32'h12345678, 32'h00000001, lat, bcnt, h, l, z, da);
    $display("MULTU 12345678*00000001 -> hi=%h lo=%h lat=%0d", h, l, lat);
    checks++; if (l !== 32'h12345678) begin errors++; $display("FAIL x1_lo: got %h want 12345678", l); end
    checks++; if (h !== 32'h00000000) begin errors++; $display("FAIL x1_hi: got %h want 00000000", h); end
    checks++; if (lat !== LAT_X1) begin errors++; $display("FAIL x1_latency: got %0d want %0d", lat, LAT_X1); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt; logic [31:0] h, l; logic z, da;
    run_op(OP_DIVU, 32'hFFFFFFFF, 32'h00000010, lat, bcnt, h, l, z, da);
    $display("DIVU ffffffff/00000010 -> hi=%h lo=%h", h, l);
    checks++; if (l !== 32'h0FFFFFFF) begin errors++; $display("FAIL b2b_divu_quot: got %h want 0fffffff", l); end
    checks++; if (h !== 32'h0000000F) begin errors++; $display("FAIL b2b_divu_rem: got %h want 0000000f", h); end
    run_op(OP_MULT, 32'h80000000, 32'h80000000, lat, bcnt, h, l, z, da);
    $display("MULT 80000000*80000000 -> hi=%h lo=%h", h, l);
    checks++; if (h !== 32'h40000000) begin errors++; $display("FAIL b2b_mult_hi: got %h want 40000000", h); end
    checks++; if (l !== 32'h00000000) begin errors++; $display("FAIL b2b_mult_lo: got %h want 00000000", l); end
    run_op(OP_DIV, 32'h00000007, 32'hFFFFFFFE, lat, bcnt, h, l, z, da);
    $display("DIV 00000007/fffffffe -> hi=%h lo=%h", h, l);
    checks++; if (l !== 32'hFFFFFFFD) begin errors++; $display("FAIL b2b_div_quot: got %h want fffffffd", l); end
    checks++; if (h !== 32'h00000001) begin errors++; $display("FAIL b2b_div_rem: got %h want 00000001", h); end
  endtask

  task automatic test_start_in_done();
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIVU; bus.rs_data = 32'h00000009; bus.rt_data = 32'h00000003;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    // In DONE: request a divide-by-zero that would complete instantly if taken.
    bus.start = 1'b1; bus.op = OP_DIVU; bus.rs_data = 32'h00000055; bus.rt_data = 32'h0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    $display("start in DONE -> done=%b busy=%b dbz=%b hi=%h lo=%h", bus.done, bus.busy, bus.div_by_zero, bus.hi, bus.lo);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_start_done: got %b want 0", bus.done); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL done_start_dbz: got %b want 0", bus.div_by_zero); end
    checks++; if (bus.lo !== 32'h00000003) begin errors++; $display("FAIL done_start_lo: got %h want 00000003", bus.lo); end
    checks++; if (bus.hi !== 32'h00000000) begin errors++; $display("FAIL done_start_hi: got %h want 00000000", bus.hi); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_multu();
    test_signed();
    test_div_by_zero();
    test_div_overflow();
    test_start_while_busy();
    test_reset_mid();
    test_early_term();
    test_back_to_back();
    test_start_in_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unidad_mult_div.md
Name: unidad_mult_div

Overview:
- Iterative multi-cycle multiply/divide unit directly downstream of the register file (BancoReg).
- Consumes ReadData1/ReadData2 as rs/rt operands; results go to HI/LO registers, which later feed the write-back mux back into the register file.
- Shift-add multiply and restoring divide at one bit per clock, with a start/busy/done handshake to the control unit.

Parameters:
- WIDTH, 32, operand/result width; only 32 is verified.
- CNT_W, 6, iteration counter width (must hold WIDTH).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU (package enum)
- rs_data  in  WIDTH  dividend / multiplicand (from ReadData1)
- rt_data  in  WIDTH  divisor / multiplier (from ReadData2)
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when hi/lo hold a new result
- div_by_zero  out  1  sticky flag for the last operation; cleared on next accepted start
- hi  out  WIDTH  MULT: upper product; DIV: remainder
- lo  out  WIDTH  MULT: lower product; DIV: quotient

Behaviour:
- Clocking and reset:
  - Single clock is clk.
  - Reset is asynchronous and active-low on rst_n.
  - While rst_n=0: state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0.
  - Reset mid-operation aborts immediately; no partial result is kept.
- FSM states: IDLE, CALC, FIX, DONE.
- Accepting an operation:
  - Edge k with state=IDLE and start=1: latch op, rs_data, rt_data; clear div_by_zero.
  - Signed ops (MULT/DIV): latch operand magnitudes plus sign bits; unsigned ops latch operands as-is.
  - Go to CALC with counter=0.
  - Exception, divide by zero: op=DIV/DIVU with rt_data=0 goes straight to DONE with hi=rs_data, lo=all-ones, div_by_zero=1.
- CALC, one iteration per edge, 32 edges (k+1..k+32), then FIX:
  - Multiply: 64-bit accumulator; if the multiplier LSB is set, add the multiplicand into the upper half; then shift right one bit.
  - Divide: shift the remainder:quotient pair left; trial-subtract the divisor; keep the result and set quotient bit 0 if non-negative.
- FIX, edge k+33:
  - MULT: negate the 64-bit product if operand signs differ.
  - DIV: negate the quotient if signs differ; the remainder takes the dividend's sign.
  - Write hi/lo, go to DONE.
- DONE, one cycle:
  - done=1; edge k+34 returns to IDLE.
  - hi/lo hold until the next accepted operation completes.
  - start asserted in DONE is ignored.
- Outputs:
  - busy = (state==CALC || state==FIX), registered with the state.
  - done is high exactly in the DONE state.
  - Normal latency: done is high in the cycle after edge k+33. Divide-by-zero latency: done is high after edge k.
- Boundary cases:
  - start while busy: ignored, no queueing.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps naturally, no trap).
  - Operand 0 for a multiply: full 32 iterations unless the optional feature is enabled.
  - op/rs_data/rt_data changing after acceptance has no effect.

Optional Feature:
- Macro: UNIDAD_MD_EARLY_TERM_EN.
- Defined: for multiply ops only, CALC goes to FIX on any edge where the remaining (shifted) multiplier bits are all zero; the accumulator is pre-aligned so the result is identical.
  - Example: MULTU x*1 gives done after edge k+3.
  - Divide latency is unchanged.
- Undefined: fixed 32-iteration CALC for all ops.

Decomposition:
- Package unidad_md_pkg holds:
  - op enum (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
  - FSM state enum
  - WIDTH default and ITER constant (32)
- One natural sub-module, md_sign_fix: combinational magnitude extraction and sign correction for operands and results, reused at latch and at FIX.

Test Plan:
- MULTU 0x0000FFFF*0x0000FFFF -> hi=0x00000000, lo=0xFFFE0001; done in cycle after edge k+33; busy high k+1..k+33.
- MULT 0xFFFFFFFD(-3)*0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV 0xFFFFFFF9(-7)/0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 0x00000064/0 -> done after edge k, div_by_zero=1, hi=0x00000064, lo=0xFFFFFFFF; the next accepted start clears div_by_zero.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, div_by_zero=0.
- start pulsed at k+5 during a MULTU -> ignored, result unchanged. rst_n low at k+10 -> busy=0, hi=lo=0 asynchronously; a new op afterwards completes correctly.
- With UNIDAD_MD_EARLY_TERM_EN: MULTU 0x12345678*0x00000001 -> lo=0x12345678, hi=0, done after edge k+3. Without it: same result at k+33.
